// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-side PC unit: jump encodings, FSM states
// and the default reset/exception/IM-window addresses.
package pc_pkg;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;
    localparam logic [31:0] PC_IM_LO_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_IM_HI_DEFAULT = 32'h0000_6ffc;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational D-stage redirect decode: branch / j / jr target and whether
// the instruction in D redirects fetch at all.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] d_pc_i,
    input  logic [15:0]       d_imm16_i,
    input  logic [25:0]       d_addr26_i,
    input  logic [ADDR_W-1:0] d_rs_data_i,
    input  logic              d_branch_i,
    input  logic [1:0]        d_jump_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] target_o
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc4_s;
    logic [ADDR_W-1:0] br_off_s;
    logic [ADDR_W-1:0] br_tgt_s;
    logic [ADDR_W-1:0] jt_tgt_s;

    assign pc4_s    = d_pc_i + PC_STEP;
    assign br_off_s = {{(ADDR_W-18){d_imm16_i[15]}}, d_imm16_i, 2'b00};
    assign br_tgt_s = pc4_s + br_off_s;

    // j/jal keeps the upper PC bits of the delay slot; none exist at 28 bits
    generate
        if (ADDR_W > 28) begin : g_jt_hi
            assign jt_tgt_s = {pc4_s[ADDR_W-1:28], d_addr26_i, 2'b00};
        end else begin : g_jt_flat
            assign jt_tgt_s = {d_addr26_i, 2'b00};
        end
    endgenerate

    // Jumps outrank branches; the reserved jump code behaves like no jump
    always_comb begin
        redirect_o = 1'b0;
        target_o   = br_tgt_s;
        case (d_jump_i)
            JMP_J: begin
                redirect_o = 1'b1;
                target_o   = jt_tgt_s;
            end
            JMP_JR: begin
                redirect_o = 1'b1;
                target_o   = d_rs_data_i;
            end
            default: begin
                if (d_branch_i) begin
                    redirect_o = 1'b1;
                    target_o   = br_tgt_s;
                end else begin
                    redirect_o = 1'b0;
                    target_o   = br_tgt_s;
                end
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// F-stage PC register with next-PC selection and an IM-ready handshake that
// parks D redirects in PEND. Define PC_ADEL_CHECK_EN to enable the AdEL flag.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_DEFAULT),
    parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(PC_EXC_DEFAULT)
`ifdef PC_ADEL_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] IM_LO    = ADDR_W'(PC_IM_LO_DEFAULT),
    parameter logic [ADDR_W-1:0] IM_HI    = ADDR_W'(PC_IM_HI_DEFAULT)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              im_ready,
    input  logic [ADDR_W-1:0] D_pc,
    input  logic [15:0]       D_imm16,
    input  logic [25:0]       D_addr26,
    input  logic [ADDR_W-1:0] D_rs_data,
    input  logic              D_branch,
    input  logic [1:0]        D_jump,
    input  logic              M_isEret,
    input  logic [ADDR_W-1:0] M_EPC,
    input  logic              M_exc,
    output logic [ADDR_W-1:0] F_pc,
    output logic              F_valid,
    output logic              F_excAdEL
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [ADDR_W-1:0] pend_q,  pend_d;
    logic              valid_q, valid_d;

    logic              d_redir_s;
    logic [ADDR_W-1:0] d_tgt_s;
    logic              m_redir_s;
    logic [ADDR_W-1:0] m_tgt_s;
    logic              adv_s;

    pc_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .d_pc_i      (D_pc),
        .d_imm16_i   (D_imm16),
        .d_addr26_i  (D_addr26),
        .d_rs_data_i (D_rs_data),
        .d_branch_i  (D_branch),
        .d_jump_i    (D_jump),
        .redirect_o  (d_redir_s),
        .target_o    (d_tgt_s)
    );

    assign m_redir_s = M_exc | M_isEret;
    assign m_tgt_s   = M_exc ? EXC_PC : M_EPC;
    assign adv_s     = im_ready & ~stall;

    // Next-state: M-stage redirects win over everything, including a parked target
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        valid_d = 1'b1;
        if (m_redir_s) begin
            pc_d    = m_tgt_s;
            pend_d  = '0;
            state_d = PC_RUN;
            valid_d = im_ready;
        end else begin
            case (state_q)
                PC_RUN: begin
                    if (adv_s) begin
                        pc_d = d_redir_s ? d_tgt_s : (pc_q + PC_STEP);
                    end else if (!stall && d_redir_s) begin
                        pend_d  = d_tgt_s;
                        state_d = PC_PEND;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                // The redirecting instruction has left D, so stall cannot hold it back
                PC_PEND: begin
                    if (im_ready) begin
                        pc_d    = pend_q;
                        state_d = PC_RUN;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: begin
                    state_d = PC_RUN;
                end
            endcase
        end
    end

    // State, PC, parked target and bubble flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PC_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            valid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    assign F_pc    = pc_q;
    assign F_valid = valid_q;

`ifdef PC_ADEL_CHECK_EN
    assign F_excAdEL = (pc_q[1:0] != 2'b00) | (pc_q < IM_LO) | (pc_q > IM_HI);
`else
    assign F_excAdEL = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// followed by randomized traffic checked against a behavioural model.
module tb_pc_unit;

`ifdef PC_ADEL_CHECK_EN
    localparam logic ADEL_ON = 1'b1;
`else
    localparam logic ADEL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall, im_ready, D_branch, M_isEret, M_exc;
    logic [31:0] D_pc, D_rs_data, M_EPC;
    logic [15:0] D_imm16;
    logic [25:0] D_addr26;
    logic [1:0]  D_jump;
    logic [31:0] F_pc;
    logic        F_valid, F_excAdEL;

    pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .im_ready  (im_ready),
        .D_pc      (D_pc),
        .D_imm16   (D_imm16),
        .D_addr26  (D_addr26),
        .D_rs_data (D_rs_data),
        .D_branch  (D_branch),
        .D_jump    (D_jump),
        .M_isEret  (M_isEret),
        .M_EPC     (M_EPC),
        .M_exc     (M_exc),
        .F_pc      (F_pc),
        .F_valid   (F_valid),
        .F_excAdEL (F_excAdEL)
    );

    always #5 clk = ~clk;

    // behavioural model state
    logic [31:0] m_pc      = 32'h0000_3000;
    logic        m_valid   = 1'b1;
    bit          m_pending = 1'b0;
    logic [31:0] m_pend_tgt = 32'h0;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    bit          lit_en   = 1'b0;
    logic [31:0] lit_pc;
    logic        lit_valid, lit_adel;

    function automatic bit d_redirects();
        return (D_jump == 2'b01) || (D_jump == 2'b10) || D_branch;
    endfunction

    function automatic logic [31:0] d_target();
        logic [31:0] pc4;
        pc4 = D_pc + 32'd4;
        if (D_jump == 2'b01) return {pc4[31:28], D_addr26, 2'b00};
        if (D_jump == 2'b10) return D_rs_data;
        return pc4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    endfunction

    function automatic logic exp_adel(input logic [31:0] pc);
        if (!ADEL_ON) return 1'b0;
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6ffc);
    endfunction

    // model: evaluates the fetch rules at every clock edge or reset rise
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_pc = 32'h0000_3000; m_valid = 1'b1; m_pending = 1'b0;
        end else begin
            m_valid = (M_exc || M_isEret) ? im_ready : 1'b1;
            if (M_exc) begin
                m_pc = 32'h0000_4180; m_pending = 1'b0;
            end else if (M_isEret) begin
                m_pc = M_EPC; m_pending = 1'b0;
            end else if (m_pending) begin
                if (im_ready) begin m_pc = m_pend_tgt; m_pending = 1'b0; end
            end else if (!stall && d_redirects()) begin
                if (im_ready) m_pc = d_target();
                else begin m_pending = 1'b1; m_pend_tgt = d_target(); end
            end else if (!stall && im_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // single compare process on the falling edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_checks = n_checks + 3;
            if (F_pc !== m_pc) begin
                n_fail = n_fail + 1;
                $display("FAIL model_pc t=%0t got=%h exp=%h", $time, F_pc, m_pc);
            end
            if (F_valid !== m_valid) begin
                n_fail = n_fail + 1;
                $display("FAIL model_valid t=%0t got=%b exp=%b", $time, F_valid, m_valid);
            end
            if (F_excAdEL !== exp_adel(m_pc)) begin
                n_fail = n_fail + 1;
                $display("FAIL model_adel t=%0t got=%b exp=%b", $time, F_excAdEL, exp_adel(m_pc));
            end
            if (lit_en) begin
                n_checks = n_checks + 3;
                if (F_pc !== lit_pc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL lit_pc t=%0t got=%h exp=%h", $time, F_pc, lit_pc);
                end
                if (F_valid !== lit_valid) begin
                    n_fail = n_fail + 1;
                    $display("FAIL lit_valid t=%0t got=%b exp=%b", $time, F_valid, lit_valid);
                end
                if (F_excAdEL !== lit_adel) begin
                    n_fail = n_fail + 1;
                    $display("FAIL lit_adel t=%0t got=%b exp=%b", $time, F_excAdEL, lit_adel);
                end
            end
        end
    end

    task automatic idle(input logic rdy);
        stall = 1'b0; im_ready = rdy; D_branch = 1'b0; D_jump = 2'b00;
        M_isEret = 1'b0; M_exc = 1'b0; D_pc = 32'h0; D_imm16 = 16'h0;
        D_addr26 = 26'h0; D_rs_data = 32'h0; M_EPC = 32'h0;
    endtask

    task automatic cyc(input logic [31:0] pc, input logic v, input logic a);
        lit_pc = pc; lit_valid = v; lit_adel = a; lit_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle(1'b1);
        @(posedge clk);
        chk_en = 1'b1;
        lit_pc = 32'h0000_3000; lit_valid = 1'b1; lit_adel = 1'b0; lit_en = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;

        // sequential fetch
        cyc(32'h0000_3004, 1'b1, 1'b0);
        cyc(32'h0000_3008, 1'b1, 1'b0);
        cyc(32'h0000_300c, 1'b1, 1'b0);

        // branch while IM busy, then release with stall asserted
        idle(1'b0); D_pc = 32'h0000_3008; D_imm16 = 16'hfffe; D_branch = 1'b1;
        cyc(32'h0000_300c, 1'b1, 1'b0);
        idle(1'b1); stall = 1'b1;
        cyc(32'h0000_3004, 1'b1, 1'b0);

        // park a branch, then exception + eret + jump + stall all at once
        idle(1'b0); D_pc = 32'h0000_3004; D_imm16 = 16'h0010; D_branch = 1'b1;
        cyc(32'h0000_3004, 1'b1, 1'b0);
        idle(1'b0); M_exc = 1'b1; M_isEret = 1'b1; M_EPC = 32'h0000_5000;
        D_jump = 2'b01; stall = 1'b1;
        cyc(32'h0000_4180, 1'b0, 1'b0);
        idle(1'b1);
        cyc(32'h0000_4184, 1'b1, 1'b0);

        // jr held off by stall
        idle(1'b1); D_jump = 2'b10; D_rs_data = 32'h0000_3400; stall = 1'b1;
        cyc(32'h0000_4184, 1'b1, 1'b0);
        stall = 1'b0;
        cyc(32'h0000_3400, 1'b1, 1'b0);

        // AdEL boundaries
        idle(1'b1); D_jump = 2'b10; D_rs_data = 32'h0000_3402;
        cyc(32'h0000_3402, 1'b1, ADEL_ON);
        D_rs_data = 32'h0000_7000;
        cyc(32'h0000_7000, 1'b1, ADEL_ON);

        // j keeps upper nibble of delay-slot PC, then eret with IM ready
        idle(1'b1); D_jump = 2'b01; D_pc = 32'h0000_2ff8; D_addr26 = 26'h0000c40;
        cyc(32'h0000_3100, 1'b1, 1'b0);
        idle(1'b1); M_isEret = 1'b1; M_EPC = 32'h0000_3200;
        cyc(32'h0000_3200, 1'b1, 1'b0);

        // reset pulsed mid-cycle while a target is parked
        idle(1'b0); D_pc = 32'h0000_3200; D_imm16 = 16'h0004; D_branch = 1'b1;
        cyc(32'h0000_3200, 1'b1, 1'b0);
        idle(1'b0);
        @(posedge clk); #2;
        reset = 1'b1;
        lit_pc = 32'h0000_3000; lit_valid = 1'b1; lit_adel = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        idle(1'b1);
        cyc(32'h0000_3004, 1'b1, 1'b0);
        lit_en = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            stall     = ($urandom_range(0, 99) < 20);
            im_ready  = ($urandom_range(0, 99) < 65);
            M_exc     = ($urandom_range(0, 99) < 4);
            M_isEret  = ($urandom_range(0, 99) < 5);
            M_EPC     = 32'h0000_3000 + {18'h0, 12'($urandom), 2'b00};
            D_branch  = ($urandom_range(0, 99) < 25);
            D_jump    = ($urandom_range(0, 99) < 30) ? 2'($urandom) : 2'b00;
            D_pc      = ($urandom_range(0, 9) == 0) ? 32'hffff_fff8 : (32'h0000_3000 + {18'h0, 12'($urandom), 2'b00});
            D_imm16   = 16'($urandom);
            D_addr26  = 26'($urandom);
            D_rs_data = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0000_2ff0 + {20'h0, 12'($urandom)});
            @(negedge clk); #1;
        end
        reset = 1'b0;
        idle(1'b1);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
